// File: rtl/instr_encoder.sv
// RV32I instruction word assembler: packs decoded fields into a 32-bit word,
// range-checks the immediate and writes accepted words sequentially to memory.
module instr_encoder #(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            cls,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [31:0]           imm,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic                  mem_ack,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  err
);

  localparam logic [ADDR_WIDTH-1:0] BASE_A  = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  localparam logic [2:0] CLS_R      = 3'd0;
  localparam logic [2:0] CLS_LOAD   = 3'd1;
  localparam logic [2:0] CLS_IALU   = 3'd2;
  localparam logic [2:0] CLS_STORE  = 3'd3;
  localparam logic [2:0] CLS_JAL    = 3'd4;
  localparam logic [2:0] CLS_BRANCH = 3'd5;
  localparam logic [2:0] CLS_LUI    = 3'd6;
  localparam logic [2:0] CLS_JALR   = 3'd7;

  typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [31:0]           word_q, word_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  err_q, err_d;
  logic [31:0]           enc_word_s;
  logic                  imm_ok_s;

  function automatic logic [31:0] encode(
    input logic [2:0]  c,
    input logic [4:0]  d,
    input logic [4:0]  s1,
    input logic [4:0]  s2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [31:0] im
  );
    logic [31:0] w;
    case (c)
      CLS_R:      w = {f7, s2, s1, f3, d, 7'd51};
      CLS_LOAD:   w = {im[11:0], s1, f3, d, 7'd3};
      CLS_IALU:   w = {im[11:0], s1, f3, d, 7'd19};
      CLS_STORE:  w = {im[11:5], s2, s1, f3, im[4:0], 7'd35};
      CLS_JAL:    w = {im[20], im[10:1], im[11], im[19:12], d, 7'd111};
      CLS_BRANCH: w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], 7'd99};
      CLS_LUI:    w = {im[31:12], d, 7'd55};
      CLS_JALR:   w = {im[11:0], s1, 3'd0, d, 7'd103};
      default:    w = 32'd0;
    endcase
    return w;
  endfunction

  // Sign-extension check: the dropped upper bits must all equal the sign bit.
  function automatic logic imm_fits(input logic [2:0] c, input logic [31:0] im);
    logic ok;
    case (c)
      CLS_LOAD, CLS_IALU, CLS_STORE, CLS_JALR:
        ok = (&im[31:11]) | ~(|im[31:11]);
      CLS_BRANCH: ok = ((&im[31:12]) | ~(|im[31:12])) & ~im[0];
      CLS_JAL:    ok = ((&im[31:20]) | ~(|im[31:20])) & ~im[0];
      default:    ok = 1'b1;
    endcase
    return ok;
  endfunction

  assign enc_word_s = encode(cls, rd, rs1, rs2, funct3, funct7, imm);
  assign imm_ok_s   = imm_fits(cls, imm);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= 32'd0;
      count_q <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      count_q <= count_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    count_d = count_q;
    full_d  = full_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid && !full_q) begin
          if (imm_ok_s) begin
            word_d  = enc_word_s;
            state_d = WRITE;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          count_d = count_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
          full_d  = (count_d == DEPTH_C);
          state_d = IDLE;
        end else begin
          state_d = WRITE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE) && !full_q;
  assign mem_we    = (state_q == WRITE);
  assign mem_addr  = BASE_A + count_q[ADDR_WIDTH-1:0];
  assign mem_wdata = word_q;
  assign count     = count_q;
  assign full      = full_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a default instance and a DEPTH=2,
// BASE_ADDR=5 instance share field inputs; a monitor checks each acked write.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_a [2];
  logic        mem_ack_a  [2];
  logic [2:0]  cls;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        in_ready_a  [2];
  logic        mem_we_a    [2];
  logic [9:0]  mem_addr_a  [2];
  logic [31:0] mem_wdata_a [2];
  logic [10:0] count_a     [2];
  logic        full_a      [2];
  logic        err_a       [2];

  int n_vec = 0;
  int n_mis = 0;
  int exp_cnt [2];
  int base_a  [2];
  logic [41:0] sb0 [$];
  logic [41:0] sb1 [$];

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_WIDTH(10), .DEPTH(1024), .BASE_ADDR(0)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]),
    .cls(cls), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm(imm), .mem_we(mem_we_a[0]), .mem_addr(mem_addr_a[0]),
    .mem_wdata(mem_wdata_a[0]), .mem_ack(mem_ack_a[0]), .count(count_a[0]),
    .full(full_a[0]), .err(err_a[0]));

  instr_encoder #(.ADDR_WIDTH(10), .DEPTH(2), .BASE_ADDR(5)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]),
    .cls(cls), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm(imm), .mem_we(mem_we_a[1]), .mem_addr(mem_addr_a[1]),
    .mem_wdata(mem_wdata_a[1]), .mem_ack(mem_ack_a[1]), .count(count_a[1]),
    .full(full_a[1]), .err(err_a[1]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every acked write must match the oldest expected {addr, word}.
  always @(negedge clk) begin
    if (mem_we_a[0] === 1'b1 && mem_ack_a[0] === 1'b1) begin
      if (sb0.size() == 0) begin
        n_vec++; n_mis++;
        $display("FAIL u0_unexpected_write: got addr %0d data 0x%08h expected none",
                 mem_addr_a[0], mem_wdata_a[0]);
      end else begin
        chk("u0_write", {22'd0, mem_addr_a[0], mem_wdata_a[0]}, {22'd0, sb0.pop_front()});
      end
    end
    if (mem_we_a[1] === 1'b1 && mem_ack_a[1] === 1'b1) begin
      if (sb1.size() == 0) begin
        n_vec++; n_mis++;
        $display("FAIL u1_unexpected_write: got addr %0d data 0x%08h expected none",
                 mem_addr_a[1], mem_wdata_a[1]);
      end else begin
        chk("u1_write", {22'd0, mem_addr_a[1], mem_wdata_a[1]}, {22'd0, sb1.pop_front()});
      end
    end
  end

  task automatic set_fields(input logic [2:0] c, input logic [4:0] d, input logic [4:0] s1,
                            input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [31:0] im);
    cls = c; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
  endtask

  // One instruction on unit u; ok selects accept vs reject, stall = ack-low cycles.
  task automatic send(input int u, input logic [2:0] c, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] im, input bit ok,
                      input logic [31:0] word, input int stall);
    logic [9:0] ea;
    @(posedge clk); #1;
    set_fields(c, d, s1, s2, f3, f7, im);
    in_valid_a[u] = 1'b1;
    @(negedge clk);
    chk("ready_before", {63'd0, in_ready_a[u]}, 64'd1);
    ea = 10'(base_a[u] + exp_cnt[u]);
    if (ok) begin
      if (u == 0) sb0.push_back({ea, word});
      else        sb1.push_back({ea, word});
    end
    @(posedge clk); #1;
    in_valid_a[u] = 1'b0;
    if (ok) begin
      for (int i = 0; i < stall; i++) begin
        mem_ack_a[u] = 1'b0;
        in_valid_a[u] = (i % 2 == 0);
        @(negedge clk);
        chk("stall_we",    {63'd0, mem_we_a[u]}, 64'd1);
        chk("stall_wdata", {32'd0, mem_wdata_a[u]}, {32'd0, word});
        chk("stall_addr",  {54'd0, mem_addr_a[u]}, {54'd0, ea});
        chk("stall_ready", {63'd0, in_ready_a[u]}, 64'd0);
        @(posedge clk); #1;
        in_valid_a[u] = 1'b0;
      end
      mem_ack_a[u] = 1'b1;
      @(negedge clk);
      chk("ack_we", {63'd0, mem_we_a[u]}, 64'd1);
      @(posedge clk); #1;
      mem_ack_a[u] = 1'b0;
      exp_cnt[u]++;
      @(negedge clk);
      chk("count_after", {53'd0, count_a[u]}, 64'(exp_cnt[u]));
      chk("ready_after", {63'd0, in_ready_a[u]}, (u == 1 && exp_cnt[u] == 2) ? 64'd0 : 64'd1);
      chk("we_after",    {63'd0, mem_we_a[u]}, 64'd0);
    end else begin
      @(negedge clk);
      chk("rej_err",   {63'd0, err_a[u]}, 64'd1);
      chk("rej_we",    {63'd0, mem_we_a[u]}, 64'd0);
      chk("rej_ready", {63'd0, in_ready_a[u]}, 64'd1);
      chk("rej_count", {53'd0, count_a[u]}, 64'(exp_cnt[u]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid_a[0] = 1'b0; in_valid_a[1] = 1'b0;
    mem_ack_a[0]  = 1'b0; mem_ack_a[1]  = 1'b0;
    set_fields(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    base_a[0]  = 0; base_a[1]  = 5;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {63'd0, in_ready_a[0]}, 64'd1);
    chk("rst_we",    {63'd0, mem_we_a[0]}, 64'd0);
    chk("rst_addr",  {54'd0, mem_addr_a[0]}, 64'd0);
    chk("rst_wdata", {32'd0, mem_wdata_a[0]}, 64'd0);
    chk("rst_count", {53'd0, count_a[0]}, 64'd0);
    chk("rst_flags", {62'd0, full_a[0], err_a[0]}, 64'd0);
    chk("rst_addr1", {54'd0, mem_addr_a[1]}, 64'd5);

    // add, lw, sw, beq, jal
    send(0, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1, 32'h002081B3, 0);
    send(0, 3'd1, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 32'd8, 1'b1, 32'h00812283, 0);
    send(0, 3'd3, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, -32'sd4, 1'b1, 32'hFE512E23, 0);
    send(0, 3'd5, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 1'b1, 32'h00208463, 0);
    send(0, 3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16, 1'b1, 32'h010000EF, 0);
    // rejects: odd jal offset, addi out of range
    send(0, 3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd17, 1'b0, 32'd0, 0);
    send(0, 3'd2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096, 1'b0, 32'd0, 0);
    // lui with 3-cycle ack stall
    send(0, 3'd6, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b1, 32'h123453B7, 3);
    chk("err_sticky", {63'd0, err_a[0]}, 64'd1);

    // DEPTH=2, BASE_ADDR=5 instance
    send(1, 3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1, 32'h002081B3, 0);
    send(1, 3'd1, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 32'd8, 1'b1, 32'h00812283, 0);
    chk("u1_full", {63'd0, full_a[1]}, 64'd1);
    @(posedge clk); #1;
    in_valid_a[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("u1_full_we",    {63'd0, mem_we_a[1]}, 64'd0);
      chk("u1_full_ready", {63'd0, in_ready_a[1]}, 64'd0);
      chk("u1_full_count", {53'd0, count_a[1]}, 64'd2);
    end
    @(posedge clk); #1;
    in_valid_a[1] = 1'b0;

    // reset while a write is pending on u0
    set_fields(3'd2, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    in_valid_a[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;
    @(negedge clk);
    chk("pend_we", {63'd0, mem_we_a[0]}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstw_we",    {63'd0, mem_we_a[0]}, 64'd0);
    chk("rstw_count", {53'd0, count_a[0]}, 64'd0);
    chk("rstw_err",   {63'd0, err_a[0]}, 64'd0);
    chk("rstw_full1", {63'd0, full_a[1]}, 64'd0);
    chk("rstw_ready1", {63'd0, in_ready_a[1]}, 64'd1);
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    // addi x1,x0,5 lands at BASE_ADDR again
    send(0, 3'd2, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h00500093, 0);

    repeat (2) @(negedge clk);
    chk("sb_drained", 64'(sb0.size() + sb1.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
